// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the digit-serial divider and its quotient-digit selector.
package bcd_pkg;

    localparam int BCD_W   = 4;
    localparam int BCD_MAX = 9;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIN
    } div_state_t;

    function automatic logic is_bcd(input bcd_digit_t d);
        return d <= bcd_digit_t'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_qdigit_sel.sv
// Combinational quotient-digit selection: q = largest k in 0..9 with k*divisor <= pr,
// rem = pr - q*divisor.
module bcd_qdigit_sel
    import bcd_pkg::*;
(
    input  logic [6:0]  pr,
    input  bcd_digit_t  divisor,
    output bcd_digit_t  q,
    output bcd_digit_t  rem
);

    logic [7:0]         w_mult [1:BCD_MAX];
    logic [BCD_MAX:1]   w_ge;
    logic [7:0]         w_sel_mult;

    // The comparison results form a thermometer code, so the highest true index wins.
    genvar gi;
    generate
        for (gi = 1; gi <= BCD_MAX; gi++) begin : g_mult
            assign w_mult[gi] = 8'(gi) * {4'b0000, divisor};
            assign w_ge[gi]   = ({1'b0, pr} >= w_mult[gi]);
        end
    endgenerate

    always_comb begin
        q          = '0;
        w_sel_mult = '0;
        for (int k = 1; k <= BCD_MAX; k++) begin
            if (w_ge[k]) begin
                q          = bcd_digit_t'(k);
                w_sel_mult = w_mult[k];
            end
        end
        rem = bcd_digit_t'({1'b0, pr} - w_sel_mult);
    end

endmodule

// File: rtl/bcd_digit_divider.sv
// Sequential packed-BCD long divider: N-digit dividend by one BCD digit,
// one quotient digit per clock, most-significant digit first.
module bcd_digit_divider
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [BCD_W*N_DIGITS-1:0]   dividend,
    input  logic [BCD_W-1:0]            divisor,
    output logic                        busy,
    output logic                        done,
    output logic [BCD_W*N_DIGITS-1:0]   quotient,
    output logic [BCD_W-1:0]            remainder,
    output logic                        error
);

    localparam int DW    = BCD_W * N_DIGITS;
    localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    div_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [DW-1:0]      r_dvd;
    logic [DW-BCD_W-1:0] r_qsh;
    logic [DW-1:0]      r_quot;
    bcd_digit_t         r_dvs;
    bcd_digit_t         r_rem;
    bcd_digit_t         r_remainder;
    logic               r_busy;
    logic               r_done;
    logic               r_error;

    logic [6:0]         w_pr;
    bcd_digit_t         w_q;
    bcd_digit_t         w_rem;
    logic [DW-1:0]      w_qsh_next;
    logic [N_DIGITS-1:0] w_digit_bad;
    logic               w_fault;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_chk
            assign w_digit_bad[gi] = !is_bcd(dividend[gi*BCD_W +: BCD_W]);
        end
    endgenerate

    assign w_fault = (divisor == '0) || !is_bcd(divisor) || (|w_digit_bad);

    // Partial remainder never exceeds 8*10+9, so 7 bits suffice.
    assign w_pr = ({3'b000, r_rem} * 7'd10) + {3'b000, r_dvd[DW-1 -: BCD_W]};

    // Only N-1 digits need to be kept; the final digit joins them on the way to the output.
    assign w_qsh_next = {r_qsh, w_q};

    bcd_qdigit_sel u_qsel (
        .pr      (w_pr),
        .divisor (r_dvs),
        .q       (w_q),
        .rem     (w_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_qsh       <= '0;
            r_quot      <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_dvd <= dividend;
                        r_dvs <= divisor;
                        r_rem <= '0;
                        r_qsh <= '0;
                        if (w_fault) begin
                            r_state     <= FIN;
                            r_error     <= 1'b1;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_quot      <= '0;
                            r_remainder <= '0;
                        end else begin
                            r_state <= DIV;
                            r_error <= 1'b0;
                            r_busy  <= 1'b1;
                            r_cnt   <= CNT_W'(N_DIGITS - 1);
                        end
                    end
                end
                DIV: begin
                    r_dvd <= {r_dvd[DW-BCD_W-1:0], {BCD_W{1'b0}}};
                    r_qsh <= w_qsh_next[DW-BCD_W-1:0];
                    r_rem <= w_rem;
                    if (r_cnt == '0) begin
                        r_state     <= FIN;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_quot      <= w_qsh_next;
                        r_remainder <= w_rem;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                FIN: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quot;
    assign remainder = r_remainder;
    assign error     = r_error;

endmodule

// File: doc/bcd_digit_divider.md
Name: bcd_digit_divider

Overview:
- Sequential BCD long divider: an N-digit packed-BCD dividend divided by a single BCD digit.
- Produces an N-digit BCD quotient and a one-digit BCD remainder.
- Inverse of the team's combinational BCD digit multiplier. Sits beside the 8-digit BCD multiplier datapath as its division engine.
- Processes one quotient digit per clock, most-significant digit first, with fixed latency.

Parameters:
- N_DIGITS, 8, number of BCD digits in dividend and quotient.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  4*N_DIGITS  packed BCD dividend; digit N_DIGITS-1 is most significant.
- divisor  input  4  BCD divisor digit.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.
- quotient  output  4*N_DIGITS  packed BCD quotient.
- remainder  output  4  BCD remainder, 0..divisor-1.
- error  output  1  operand fault flag, valid while done is high and held afterwards.

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE.
  - busy, done, error = 0; quotient = 0; remainder = 0.
  - Internal shift register and partial remainder are cleared.
  - Applies at any time, including mid-operation. The in-flight operation is discarded and no done pulse occurs.
- States: IDLE, DIV, FIN.
- IDLE: at a clock edge with start=1 (edge E0), latch dividend and divisor, clear the partial remainder and the quotient shift register, and check the operands.
  - Operand fault: divisor=0, divisor>9, or any dividend digit >9. Go to FIN with error=1, quotient=0, remainder=0.
  - Otherwise: go to DIV with busy=1, error=0, and the digit counter set to N_DIGITS-1.
- DIV: at edges E1..EN, one digit per edge, MSB first.
  - pr = 10*rem + d[i]. pr is an internal 7-bit binary value, max 89.
  - q = largest k in 0..9 with k*divisor <= pr.
  - rem = pr - q*divisor.
  - q is shifted into the quotient LSB; rem is held as BCD 0..8.
  - The counter decrements each edge. After the edge that processes digit 0, go to FIN.
- FIN: done=1 and busy=0 for exactly one cycle. quotient and remainder are valid.
  - The next edge returns to IDLE and done drops.
  - quotient, remainder and error hold until the next accepted start.
- Latency: a valid start sampled at E0 gives done high in the cycle after E(N_DIGITS), i.e. N_DIGITS+1 cycles after acceptance. A fault start gives done high in the cycle after E0.
- start while busy=1 or done=1 is ignored; it is not queued. Back-to-back operation: start asserted in the cycle after done is accepted.
- Operands are ignored except at the accepting edge; they may change during DIV.
- Leading zero digits in the quotient are emitted as 0000; no suppression.
- quotient and remainder are never X. Internally the quotient shifts in place; the outputs update only on entry to FIN.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_W=4 and BCD_MAX=9 constants;
  - the divider state enum {IDLE, DIV, FIN};
  - a bcd_digit_t typedef.
- Sub-module bcd_qdigit_sel (combinational): inputs pr[6:0] and divisor[3:0]; outputs q[3:0] and rem[3:0].
  - Implemented as a compare against the multiples 1..9 of the divisor.
  - Reusable by a future multi-digit-divisor engine.
- The top module holds the FSM, the counter and the registers.

Test Plan:
- dividend=0x12345678, divisor=3 -> done exactly 9 cycles after the start edge; quotient=0x04115226, remainder=0, error=0.
- dividend=0x99999999, divisor=7 -> quotient=0x14285714, remainder=1. Then dividend=0x87654321, divisor=8 back-to-back (start the cycle after done) -> quotient=0x10956790, remainder=1.
- dividend=0x00000005, divisor=9 -> quotient=0x00000000, remainder=5. Then divisor=1 with dividend=0x00000005 -> quotient=0x00000005, remainder=0.
- Faults:
  - divisor=0 -> done in the cycle after the start edge, error=1, quotient=0, remainder=0.
  - Repeat with divisor=4'hA -> same result.
  - Repeat with dividend=0x123C5678, divisor=3 -> same result.
- Hold start high continuously with dividend=0x00000100, divisor=4:
  - exactly one done every 10 cycles, each with quotient=0x00000025, remainder=0;
  - busy stays 1 through DIV;
  - changing the operands during DIV has no effect.
- Assert rst_n low mid-DIV at cycle 4 of a 0x12345678/3 operation:
  - all outputs go to 0 immediately (asynchronously), with no done pulse;
  - after release, a new start with 0x00000009/3 gives quotient=0x00000003, remainder=0.
